apc_stream_ctrl: RTL

Run controller for the 16-input approximate-parallel-counter (APC) stochastic adder. On `start`, it runs one evaluation of programmable bitstream length. It drives the adder's 4-bit comparison random number from an on-block LFSR and strobes the upstream stochastic number generators. It also counts the adder's output ones, with compensation for a fixed datapath latency, and reports the final count with a done pulse. It sits between the system control logic and the adder/SNG datapath.

---
 rtl/apc_stream_ctrl_if.sv | 25 ++
 rtl/apc_stream_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/apc_stream_ctrl_if.sv
// Handshake/bus bundle between the APC run controller
// and the system control logic plus adder/SNG datapath.
interface apc_stream_ctrl_if #(
  parameter int LEN_W = 10
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] len;
  logic             apc_out;
  logic             stream_en;
  logic [3:0]       rand_num;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] result;

  modport master (
    output start, abort, len, apc_out,
    input  stream_en, rand_num, busy, done, result
  );

  modport slave (
    input  start, abort, len, apc_out,
    output stream_en, rand_num, busy, done, result
  );
endinterface

// File: rtl/apc_stream_ctrl.sv
// Run controller for the 16-input APC stochastic adder:
// LFSR comparison source, SNG strobe, latency-aligned ones count.
module apc_stream_ctrl #(
  parameter int         LEN_W = 10,
  parameter int         LAT   = 0,
  parameter logic [3:0] SEED  = 4'h1
) (
  input  logic clk,
  input  logic rst,
  apc_stream_ctrl_if.slave bus
);

  localparam logic [3:0] SEED_EFF =
    (SEED == 4'h0) ? 4'h1 : SEED;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] acc;
  logic [LEN_W-1:0] acc_next;
  logic [LEN_W-1:0] result_q;
  logic [3:0]       lfsr;
  logic             stream_en_q;
  logic             busy_q;
  logic             done_q;
  logic             valid;
  logic             drain_last;
  logic             accept;

  assign accept = (state == IDLE) && bus.start
                  && !bus.abort;

  assign acc_next = acc
    + {{(LEN_W-1){1'b0}}, valid & bus.apc_out};

  generate
    if (LAT == 0) begin : g_nolat
      assign valid      = stream_en_q;
      assign drain_last = 1'b1;
    end else begin : g_lat
      logic [LAT-1:0] vpipe;
      logic [LAT-1:0] vshift;

      assign vshift     = vpipe << 1;
      assign valid      = vpipe[LAT-1];
      assign drain_last = (vshift == '0);

      // Delay stream_en to line up with the adder's output bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vpipe <= '0;
        end else if (bus.abort || accept) begin
          vpipe <= '0;
        end else begin
          vpipe <= vshift | LAT'(stream_en_q);
        end
      end
    end
  endgenerate

  // Run FSM with counter, LFSR, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      acc         <= '0;
      lfsr        <= SEED_EFF;
      stream_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      acc    <= acc_next;
      done_q <= 1'b0;
      if (bus.abort) begin
        state       <= IDLE;
        stream_en_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              rem    <= bus.len;
              acc    <= '0;
              lfsr   <= SEED_EFF;
              busy_q <= 1'b1;
              if (bus.len != '0) begin
                state       <= RUN;
                stream_en_q <= 1'b1;
              end else begin
                state    <= DONE;
                done_q   <= 1'b1;
                result_q <= '0;
              end
            end
          end
          RUN: begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            if (rem > LEN_W'(1)) begin
              rem <= rem - LEN_W'(1);
            end else begin
              stream_en_q <= 1'b0;
              if (LAT > 0) begin
                state <= DRAIN;
              end else begin
                state    <= DONE;
                done_q   <= 1'b1;
                result_q <= acc_next;
              end
            end
          end
          DRAIN: begin
            if (drain_last) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= acc_next;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.stream_en = stream_en_q;
  assign bus.rand_num  = lfsr;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule
